pipe_stage_skid: RTL and testbench

//  Parametrised elastic pipeline-stage register: next generation of the fixed-field stage registers (if/id, id/ex, ex/mem, mem/wb).

---
 rtl/pipe_stage_skid_pkg.sv | 13 +
 rtl/rooth_defines.sv | 11 +
 rtl/pipe_skid_slot.sv | 39 +++
 rtl/pipe_stage_skid.sv | 134 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Local types for the elastic stage register: control FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package pipe_stage_skid_pkg;

    // Encoding equals the number of valid slots, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/rooth_defines.sv
// Shared hazard-unit flow-control codes used by every pipeline stage register.
// Latency: n/a (constants only).
// Backpressure: n/a; WORK moves data, STOP freezes a stage, REFRESH flushes it.
package rooth_defines;

    localparam int               FLOW_WIDTH   = 2;
    localparam [FLOW_WIDTH-1:0]  FLOW_WORK    = 2'd0;
    localparam [FLOW_WIDTH-1:0]  FLOW_STOP    = 2'd1;
    localparam [FLOW_WIDTH-1:0]  FLOW_REFRESH = 2'd2;

endpackage

// File: rtl/pipe_skid_slot.sv
// One payload register of the skid stage with load and flush-clear enables.
// Latency: 1 cycle from ld to q.
// Backpressure: none; the owning FSM decides when to load.
//
// Ports:
//   clk  clock          rst  sync active-high reset, always zeroes the slot
//   clr  flush request  (zeroes the slot only when CLEAR_ON_FLUSH != 0)
//   ld   load enable    d    next payload    q   stored payload
module pipe_skid_slot #(
    parameter int DATA_W         = 64,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              ld,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic clr_en;

    generate
        if (CLEAR_ON_FLUSH) begin : g_clear_on_flush
            assign clr_en = 1'b1;
        end else begin : g_keep_on_flush
            assign clr_en = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || (clr && clr_en)) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: 2-entry skid buffer with hazard flow control.
// Latency: 1 cycle from push into an empty stage to out_valid_o; 1 payload/cycle sustained.
// Backpressure: in_ready_o = WORK & skid empty, registered-only (never from out_ready_i).
//
// Ports:
//   clk, rst                        clock, sync active-high reset
//   flow_i                          WORK / STOP / REFRESH (other codes flush like REFRESH)
//   in_valid_i/in_ready_o/in_data_i upstream handshake and payload
//   out_valid_o/out_ready_i/out_data_o downstream handshake and main-slot payload
//   occupancy_o                     valid slots (0..2)
//   stall_cnt_o                     saturating count of blocked WORK cycles
module pipe_stage_skid
    import rooth_defines::*;
    import pipe_stage_skid_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter bit CLEAR_ON_FLUSH = 1'b1,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLOW_WIDTH-1:0] flow_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_W-1:0]     in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_W-1:0]     out_data_o,
    output logic [1:0]            occupancy_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    skid_state_e       state, state_nxt;
    logic              work, flush;
    logic              skid_vld;
    logic              push, pop;
    logic              main_ld, main_from_skid, skid_ld;
    logic [DATA_W-1:0] main_d, main_q, skid_q;

    // Anything that is neither WORK nor STOP is treated as a flush.
    assign work  = (flow_i == FLOW_WORK);
    assign flush = !work && (flow_i != FLOW_STOP);

    assign skid_vld    = (state == ST_TWO);
    assign out_valid_o = (state != ST_EMPTY);
    assign in_ready_o  = work && !skid_vld;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i && work;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (push) begin
                        state_nxt = ST_ONE;
                        main_ld   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_ld = 1'b1;
                    end else if (push) begin
                        state_nxt = ST_TWO;
                        skid_ld   = 1'b1;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Skid holds the younger payload; it moves up to main on pop.
                    if (pop) begin
                        state_nxt      = ST_ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data_i;

    pipe_skid_slot #(
        .DATA_W         (DATA_W),
        .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
    ) u_main_slot (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .ld  (main_ld),
        .d   (main_d),
        .q   (main_q)
    );

    pipe_skid_slot #(
        .DATA_W         (DATA_W),
        .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
    ) u_skid_slot (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .ld  (skid_ld),
        .d   (in_data_i),
        .q   (skid_q)
    );

    // Counts cycles the stage is blocked by downstream; STOP/flush cycles do not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
        end else if (work && out_valid_o && !out_ready_i && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

    assign out_data_o  = main_q;
    assign occupancy_o = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;
    import rooth_defines::*;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;

    logic                  clk;
    logic                  rst;
    logic [FLOW_WIDTH-1:0] flow;
    logic                  in_valid;
    logic [DATA_W-1:0]     in_data;
    logic                  out_ready;

    logic                  in_ready,  in_ready_nc;
    logic                  out_valid, out_valid_nc;
    logic [DATA_W-1:0]     out_data,  out_data_nc;
    logic [1:0]            occ,       occ_nc;
    logic [CNT_W-1:0]      stall,     stall_nc;

    int n_cmp;
    int n_bad;

    pipe_stage_skid #(
        .DATA_W         (DATA_W),
        .CLEAR_ON_FLUSH (1'b1),
        .CNT_W          (CNT_W)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .flow_i      (flow),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .occupancy_o (occ),
        .stall_cnt_o (stall)
    );

    // Same stimulus, but a flush leaves the data slots untouched.
    pipe_stage_skid #(
        .DATA_W         (DATA_W),
        .CLEAR_ON_FLUSH (1'b0),
        .CNT_W          (CNT_W)
    ) u_dut_nc (
        .clk         (clk),
        .rst         (rst),
        .flow_i      (flow),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_nc),
        .in_data_i   (in_data),
        .out_valid_o (out_valid_nc),
        .out_ready_i (out_ready),
        .out_data_o  (out_data_nc),
        .occupancy_o (occ_nc),
        .stall_cnt_o (stall_nc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        flow      = FLOW_WORK;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occ, 0);
        chk("rst_stall", stall, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data_nc", out_data_nc, 0);

        // Streaming at full rate
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h11; step();
        chk("stream_d0", out_data, 64'h11);
        chk("stream_occ0", occ, 1);
        in_data   = 64'h22; step();
        chk("stream_d1", out_data, 64'h22);
        chk("stream_occ1", occ, 1);
        in_data   = 64'h33; step();
        chk("stream_d2", out_data, 64'h33);
        chk("stream_occ2", occ, 1);
        in_valid  = 1'b0; step();
        chk("stream_drained", occ, 0);
        chk("stream_stall", stall, 0);

        // Backpressure fills the skid slot
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hA1; step();
        in_data   = 64'hA2; step();
        chk("bp_occ", occ, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head", out_data, 64'hA1);
        chk("bp_stall1", stall, 1);
        in_valid  = 1'b0; step();
        chk("bp_stall2", stall, 2);
        chk("bp_hold_occ", occ, 2);
        out_ready = 1'b1; step();
        chk("bp_pop0", out_data, 64'hA2);
        chk("bp_pop0_occ", occ, 1);
        step();
        chk("bp_pop1_valid", out_valid, 0);
        chk("bp_stall_end", stall, 2);

        // STOP freezes a full stage
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hB1; step();
        in_data   = 64'hB2; step();
        chk("stop_pre_stall", stall, 3);
        flow      = FLOW_STOP;
        out_ready = 1'b1;
        in_data   = 64'hEE;
        #1;
        chk("stop_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) out_ready = 1'b0;
            step();
            chk("stop_data", out_data, 64'hB1);
            chk("stop_occ", occ, 2);
            chk("stop_stall", stall, 3);
        end
        flow      = FLOW_WORK;
        in_valid  = 1'b0;
        out_ready = 1'b1; step();
        chk("stop_drain0", out_data, 64'hB2);
        step();
        chk("stop_drain_occ", occ, 0);

        // REFRESH flushes a full stage, input discarded
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hC1; step();
        in_data   = 64'hC2; step();
        chk("flush_pre_stall", stall, 4);
        flow      = FLOW_REFRESH;
        out_ready = 1'b1;
        in_data   = 64'hFF;
        #1;
        chk("flush_in_ready", in_ready, 0);
        step();
        chk("flush_occ", occ, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_data_clr", out_data, 0);
        chk("flush_occ_nc", occ_nc, 0);
        chk("flush_data_keep_nc", out_data_nc, 64'hC1);
        chk("flush_stall", stall, 4);
        flow      = FLOW_WORK;
        in_valid  = 1'b0; step();
        chk("flush_post_valid", out_valid, 0);
        chk("flush_post_valid_nc", out_valid_nc, 0);

        // Undefined flow code behaves as a flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hD1; step();
        chk("undef_pre_occ", occ, 1);
        flow      = 2'd3;
        in_data   = 64'hD2; step();
        chk("undef_occ", occ, 0);
        chk("undef_data_nc", out_data_nc, 64'hD1);
        chk("undef_stall", stall, 4);
        flow      = FLOW_WORK;

        // Stall counter saturation, then reset mid-stream
        in_data   = 64'hE1; step();
        in_valid  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 4) chk("sat_mid", stall, 9);
        end
        chk("sat_stall", stall, 4'hF);
        chk("sat_data", out_data, 64'hE1);
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_occ", occ, 0);
        chk("mrst_stall", stall, 0);
        chk("mrst_data", out_data, 0);
        chk("mrst_data_nc", out_data_nc, 0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
